bit_serial_add_ctrl: RTL and testbench

Sequencing controller plus datapath for the bit-serial adder. It captures two WIDTH-bit operands into rotating shift registers and adds them LSB-first through one full adder and a carry flip-flop, one bit per clock. It assembles the sum serially and presents the result with a start/ready/busy/done handshake. It sits between the operand source and any consumer of the sum.

---
 rtl/bit_serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: operands rotate LSB-first through one full adder and a carry
// flop; the result is published only on completion. Optional subtract: BIT_SERIAL_SUB_EN.
module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only while ready=1; an accepted request is
    // answered by a single-cycle done pulse with sum/cout already stable.
    // There is no result back-pressure; sum/cout hold until the next completion.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             c;
    logic             s;
    logic             c_nxt;
    logic             accept;
    logic             last_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef BIT_SERIAL_SUB_EN
    // Two's-complement subtract: invert B and inject the +1 through the carry.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign s          = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nxt      = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign last_shift = (state == SHIFT) && (counter == LAST);
    assign state_dbg  = 2'(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            c       <= 1'b0;
            counter <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b_load;
            c       <= c_load;
            counter <= '0;
            sum_sr  <= '0;
        end else if (busy) begin
            // Rotating rather than shifting leaves the operands intact after WIDTH steps.
            a_sr    <= {a_sr[0], a_sr[WIDTH-1:1]};
            b_sr    <= {b_sr[0], b_sr[WIDTH-1:1]};
            sum_sr  <= {s, sum_sr[WIDTH-1:1]};
            c       <= c_nxt;
            counter <= counter + CW'(1);
            if (last_shift) begin
                sum  <= {s, sum_sr[WIDTH-1:1]};
                cout <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed bench for bit_serial_add_ctrl: a driver pushes hand-computed results
// into a queue and a done-triggered monitor pops and compares them.
module tb_bit_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       state_dbg;

    logic [WIDTH:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    bit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (op_a),
        .b         (op_b),
        .cin       (op_cin),
`ifdef BIT_SERIAL_SUB_EN
        .sub       (op_sub),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got sum=%h cout=%b, required no done pulse", sum, cout);
            end else begin
                check("result", 32'({cout, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0, required ready=1 within 40 cycles");
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic isub, input logic push,
                         input logic [WIDTH:0] e);
        wait_idle();
        op_a   = ia;
        op_b   = ib;
        op_cin = ic;
        op_sub = isub;
        start  = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input logic isub, input logic [WIDTH:0] e);
        issue(ia, ib, ic, isub, 1'b1, e);
        wait_idle();
    endtask

    initial begin
        int nb;
        int dk;
        int rk;
        int d1;
        int d2;
        logic hold_bad;

        rst    = 1'b1;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        op_sub = 1'b0;

        // 1: reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'h00);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;

        // 2: 3C + 0F, latency profile
        issue(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 9'h04B);
        nb = 0; dk = 0; rk = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done && dk == 0) dk = k;
            if (ready && rk == 0) rk = k;
        end
        check("busy_cycles", 32'(nb), 32'd8);
        check("done_cycle", 32'(dk), 32'd9);
        check("ready_return", 32'(rk), 32'd10);

        // asynchronous reset between edges clears the held result
        #2 rst = 1'b1;
        #1;
        check("async_rst_sum", 32'(sum), 32'h00);
        check("async_rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 3: wrap with carry, then sum must hold across the next operation
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 9'h1FF);
        hold_bad = 1'b0;
        for (int k = 0; k < 20 && !ready; k++) begin
            @(negedge clk);
            if (!done && !ready && (sum !== 8'h00 || cout !== 1'b1)) hold_bad = 1'b1;
        end
        check("sum_hold", 32'(hold_bad), 32'd0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100);

        // 4: start during SHIFT is ignored
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 9'h046);
        repeat (3) @(negedge clk);
        op_a  = 8'hAA;
        op_b  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // 4b: start held high -> back-to-back operations
        op_a   = 8'h01;
        op_b   = 8'h02;
        op_cin = 1'b0;
        start  = 1'b1;
        exp_q.push_back(9'h003);
        exp_q.push_back(9'h00B);
        @(posedge clk);
        #1;
        op_a = 8'h05;
        op_b = 8'h06;
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 11) start = 1'b0;
            if (done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
        end
        check("b2b_first_done", 32'(d1), 32'd9);
        check("b2b_spacing", 32'(d2 - d1), 32'd10);

        // 5: reset on the 4th shift cycle aborts without a done pulse
        issue(8'h55, 8'h22, 1'b0, 1'b0, 1'b0, 9'h000);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'h00);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 9'h002);

`ifdef BIT_SERIAL_SUB_EN
        // 6: subtract, cin ignored
        run_op(8'h10, 8'h03, 1'b0, 1'b1, 9'h10D);
        run_op(8'h03, 8'h10, 1'b1, 1'b1, 9'h0F3);
        run_op(8'h10, 8'h03, 1'b1, 1'b0, 9'h014);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
